// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
//   Memory / response-collection stage between execute and writeback. The
//   instruction held here may owe one response each from the data SRAM, the
//   multiplier and the divider. Each unit has a small tracker that waits for
//   the response, buffers it while the stage is stalled downstream, and drains
//   a response orphaned by a flush. Load data is formatted here, the mul/div
//   half is selected, and the final result plus exception info is registered
//   for WB.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           handshake with EX
//   out_valid / out_ready         handshake with WB (out_valid registered)
//   ex_flush, ertn_flush          pipeline flush
//   result, pc, mem_op, mul_op, div_op, res_from_*, gr_we, ertn, dest,
//   has_exception, ecode, esubcode, exception_maddr      EX payload
//   data_ok, rdata                data-SRAM response (always accepted)
//   mul_resp_valid/ready, mul_result                     multiplier response
//   div_resp_valid/ready, div_q, div_r                   divider response
//   this_exception                exception/ertn held here (EX squashes)
//   fwd_valid/ready/dest/data     bypass to ID
//   result_out ... badv_out       registered WB payload
// ----------------------------------------------------------------------------
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        ex_flush,
    input  logic        ertn_flush,
    input  logic [31:0] result,
    input  logic [31:0] pc,
    input  logic [7:0]  mem_op,
    input  logic [2:0]  mul_op,
    input  logic [3:0]  div_op,
    input  logic        res_from_mem,
    input  logic        res_from_mul,
    input  logic        res_from_div,
    input  logic        res_from_csr,
    input  logic        gr_we,
    input  logic        ertn,
    input  logic [4:0]  dest,
    input  logic        has_exception,
    input  logic [5:0]  ecode,
    input  logic [8:0]  esubcode,
    input  logic [31:0] exception_maddr,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    input  logic        mul_resp_valid,
    output logic        mul_resp_ready,
    input  logic [63:0] mul_result,
    input  logic        div_resp_valid,
    output logic        div_resp_ready,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        this_exception,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dest,
    output logic        fwd_ready,
    output logic [31:0] fwd_data,
    output logic [31:0] result_out,
    output logic [31:0] pc_out,
    output logic        gr_we_out,
    output logic        has_exception_out,
    output logic        ertn_out,
    output logic [4:0]  dest_out,
    output logic [5:0]  ecode_out,
    output logic [8:0]  esubcode_out,
    output logic [31:0] badv_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUF, S_DROP} resp_state_e;

    resp_state_e mem_state_q, mem_state_d;
    resp_state_e mul_state_q, mul_state_d;
    resp_state_e div_state_q, div_state_d;
    logic [31:0] mem_buf_q, mul_buf_q, div_buf_q;

    logic        out_valid_q;
    logic [31:0] result_q, pc_q, badv_q;
    logic        gr_we_q, has_exception_q, ertn_q;
    logic [4:0]  dest_q;
    logic [5:0]  ecode_q;
    logic [8:0]  esubcode_q;

    logic flush, owe_mem, owe_mul, owe_div;
    logic mem_fire, mul_fire, div_fire;
    logic mem_done, mul_done, div_done, any_drop, units_ok;
    logic ready_go, advance;
    logic [31:0] mem_data, mul_data, div_data, load_data, final_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Word width word/default-load, CSR source and the redundant op bits carry no extra info here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, res_from_csr, mem_op[2], mul_op[2:1], div_op[3], div_op[1]};

    assign flush   = ex_flush | ertn_flush;
    // An excepting instruction never issued its requests, so it owes nothing.
    assign owe_mem = in_valid & ~has_exception & (res_from_mem | (|mem_op[7:5]));
    assign owe_mul = in_valid & ~has_exception & res_from_mul;
    assign owe_div = in_valid & ~has_exception & res_from_div;

    assign mul_resp_ready = (mul_state_q != S_BUF);
    assign div_resp_ready = (div_state_q != S_BUF);
    assign mem_fire = data_ok;
    assign mul_fire = mul_resp_valid & mul_resp_ready;
    assign div_fire = div_resp_valid & div_resp_ready;

    // A response arriving while draining belongs to a flushed instruction.
    assign mem_done = (mem_state_q == S_BUF) | (mem_fire & (mem_state_q != S_DROP));
    assign mul_done = (mul_state_q == S_BUF) | (mul_fire & (mul_state_q != S_DROP));
    assign div_done = (div_state_q == S_BUF) | (div_fire & (div_state_q != S_DROP));
    assign any_drop = (mem_state_q == S_DROP) | (mul_state_q == S_DROP) | (div_state_q == S_DROP);
    assign units_ok = (~owe_mem | mem_done) & (~owe_mul | mul_done) & (~owe_div | div_done);

    assign ready_go = ~in_valid | flush | (units_ok & ~any_drop);
    assign advance  = in_valid & ready_go & out_ready;
    assign in_ready = ~rst & (~in_valid | (ready_go & out_ready));

    assign this_exception = in_valid & (has_exception | ertn);
    assign fwd_valid = in_valid & gr_we & (dest != 5'd0);
    assign fwd_ready = fwd_valid & units_ok & ~any_drop;
    assign fwd_dest  = dest;
    assign fwd_data  = final_data;

    assign mem_data = (mem_state_q == S_BUF) ? mem_buf_q : rdata;
    assign mul_data = (mul_state_q == S_BUF) ? mul_buf_q
                    : (mul_op[0] ? mul_result[31:0] : mul_result[63:32]);
    assign div_data = (div_state_q == S_BUF) ? div_buf_q
                    : ((div_op[0] | div_op[2]) ? div_q : div_r);

    assign load_byte = mem_data[{result[1:0], 3'b000} +: 8];
    assign load_half = mem_data[{result[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        load_data = mem_data;
        if (mem_op[0])      load_data = {{24{load_byte[7]}}, load_byte};
        else if (mem_op[3]) load_data = {24'd0, load_byte};
        else if (mem_op[1]) load_data = {{16{load_half[15]}}, load_half};
        else if (mem_op[4]) load_data = {16'd0, load_half};

        final_data = result;
        if (owe_mem & res_from_mem) final_data = load_data;
        else if (owe_mul)           final_data = mul_data;
        else if (owe_div)           final_data = div_data;
    end

    // Flush beats advance: an unanswered request must be drained even if the
    // flushed instruction is being retired this cycle.
    function automatic resp_state_e next_state(resp_state_e cur, logic owed, logic fire,
                                               logic flush_now, logic adv);
        next_state = cur;
        if (cur == S_DROP) begin
            if (fire) next_state = S_IDLE;
        end else if (flush_now) begin
            next_state = (((cur == S_WAIT) || (cur == S_IDLE && owed)) && !fire) ? S_DROP : S_IDLE;
        end else if (adv) begin
            next_state = S_IDLE;
        end else if (cur != S_BUF) begin
            next_state = !owed ? S_IDLE : (fire ? S_BUF : S_WAIT);
        end
    endfunction

    assign mem_state_d = next_state(mem_state_q, owe_mem, mem_fire, flush, advance);
    assign mul_state_d = next_state(mul_state_q, owe_mul, mul_fire, flush, advance);
    assign div_state_d = next_state(div_state_q, owe_div, div_fire, flush, advance);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            mem_state_q     <= S_IDLE;
            mul_state_q     <= S_IDLE;
            div_state_q     <= S_IDLE;
            out_valid_q     <= 1'b0;
            result_q        <= 32'd0;
            pc_q            <= RESET_PC;
            gr_we_q         <= 1'b0;
            has_exception_q <= 1'b0;
            ertn_q          <= 1'b0;
            dest_q          <= 5'd0;
            ecode_q         <= 6'd0;
            esubcode_q      <= 9'd0;
            badv_q          <= 32'd0;
        end else begin
            mem_state_q <= mem_state_d;
            mul_state_q <= mul_state_d;
            div_state_q <= div_state_d;
            if (flush)          out_valid_q <= 1'b0;
            else if (out_ready) out_valid_q <= in_valid & ready_go;
            if (advance) begin
                result_q        <= final_data;
                pc_q            <= pc;
                gr_we_q         <= gr_we;
                has_exception_q <= has_exception;
                ertn_q          <= ertn;
                dest_q          <= dest;
                ecode_q         <= ecode;
                esubcode_q      <= esubcode;
                badv_q          <= exception_maddr;
            end
        end
    end

    // NOTE: response buffers are plain datapath storage, only read in BUF, so they carry no reset.
    always_ff @(posedge clk) begin
        if (mem_state_q != S_BUF && mem_fire) mem_buf_q <= rdata;
        if (mul_state_q != S_BUF && mul_fire) mul_buf_q <= mul_op[0] ? mul_result[31:0] : mul_result[63:32];
        if (div_state_q != S_BUF && div_fire) div_buf_q <= (div_op[0] | div_op[2]) ? div_q : div_r;
    end

    assign out_valid         = out_valid_q;
    assign result_out        = result_q;
    assign pc_out            = pc_q;
    assign gr_we_out         = gr_we_q;
    assign has_exception_out = has_exception_q;
    assign ertn_out          = ertn_q;
    assign dest_out          = dest_q;
    assign ecode_out         = ecode_q;
    assign esubcode_out      = esubcode_q;
    assign badv_out          = badv_q;

endmodule
